// File: rtl/ifetch_queue.sv
// Instruction fetch front end: sequential imem requests, prefetch FIFO, redirect flush.
// Optional IFQ_STARVE_CNT_EN adds a saturating starve-cycle counter output.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid
`ifdef IFQ_STARVE_CNT_EN
    ,
    output logic [15:0] starve_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

    logic [31:0] fetch_pc;
    logic [31:0] req_pc;
    logic        inflight;
    logic [AW:0] count;
    logic [AW:0] count_next;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0] data_q [DEPTH];
    logic [31:0] pc_q [DEPTH];
    logic [AW+1:0] occ;
    logic        push;
    logic        pop;

    assign occ = {1'b0, count} + {{(AW+1){1'b0}}, inflight};
    assign imem_req = rst_n && !redirect && (occ < DEPTH_W);
    assign imem_addr = fetch_pc;
    assign push = inflight && !redirect;
    assign pop = (count != '0) && !stall && !redirect;

    // Head outputs come straight from FIFO storage; NOP when empty.
    always_comb begin
        ir_valid = 1'b0;
        ir = 32'h0;
        ir_pc = 32'h0;
        if (count != '0) begin
            ir_valid = 1'b1;
            ir = data_q[rd_ptr];
            ir_pc = pc_q[rd_ptr];
        end
    end

    // Occupancy update from push/pop.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10: count_next = count + 1'b1;
            2'b01: count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Control state: pointers, count, in-flight tracking and fetch PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            req_pc <= 32'h0;
            inflight <= 1'b0;
            count <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            inflight <= 1'b0;
            count <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            inflight <= imem_req;
            count <= count_next;
            if (imem_req) begin
                req_pc <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr] <= imem_rdata;
            pc_q[wr_ptr] <= req_pc;
        end
    end

`ifdef IFQ_STARVE_CNT_EN
    // Saturating count of cycles with no instruction presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 16'h0;
        end else if (!ir_valid && starve_cnt != 16'hFFFF) begin
            starve_cnt <= starve_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed steps plus a fetch scoreboard.
// Compile with IFQ_STARVE_CNT_EN to also cover the starve counter.
module tb_ifetch_queue;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
`ifdef IFQ_STARVE_CNT_EN
    logic [15:0] starve_cnt;
    logic [15:0] s0;
`endif

    int compared = 0;
    int mismatched = 0;
    logic [63:0] sb [$];

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .ir(ir),
        .ir_pc(ir_pc),
        .ir_valid(ir_valid)
`ifdef IFQ_STARVE_CNT_EN
        ,
        .starve_cnt(starve_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        case (a)
            32'h0: return 32'h4470_7fff;
            32'h4: return 32'h0487_b400;
            32'h8: return 32'h0ac4_2000;
            32'hC: return 32'h10e6_2800;
            default: return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Instruction memory with one-cycle read latency.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= memword(imem_addr);
        else imem_rdata <= 32'hDEAD_BEEF;
    end

    // Scoreboard: push issued fetches, compare the head, pop on consume.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst_n || redirect) begin
            sb.delete();
        end else begin
            if (ir_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_pc", ir_pc, 32'hFFFF_FFFF);
                end else begin
                    e = sb[0];
                    chk("sb_ir_pc", ir_pc, e[63:32]);
                    chk("sb_ir", ir, e[31:0]);
                    if (!stall) void'(sb.pop_front());
                end
            end else begin
                chk("sb_nop_ir", ir, 32'h0);
                chk("sb_nop_pc", ir_pc, 32'h0);
            end
            if (imem_req) begin
                chk("sb_align", {30'h0, imem_addr[1:0]}, 32'h0);
                sb.push_back({imem_addr, memword(imem_addr)});
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        repeat (3) cyc();
        chk("rst_valid", ir_valid, 0);
        chk("rst_ir", ir, 0);
        chk("rst_pc", ir_pc, 0);
        chk("rst_req", imem_req, 0);

        // Initial fill, no stalls.
        rst_n = 1'b1;
        #1;
        chk("c0_req", imem_req, 1);
        chk("c0_addr", imem_addr, 32'h0);
        cyc();
        chk("c1_addr", imem_addr, 32'h4);
        chk("c1_valid", ir_valid, 0);
        cyc();
        chk("c2_addr", imem_addr, 32'h8);
        chk("c2_valid", ir_valid, 1);
        chk("c2_ir", ir, 32'h4470_7fff);
        chk("c2_pc", ir_pc, 32'h0);
`ifdef IFQ_STARVE_CNT_EN
        chk("starve_fill", starve_cnt, 2);
`endif
        cyc();
        chk("c3_addr", imem_addr, 32'hC);
        chk("c3_ir", ir, 32'h0487_b400);
        chk("c3_pc", ir_pc, 32'h4);
        cyc();
        chk("c4_ir", ir, 32'h0ac4_2000);
        chk("c4_pc", ir_pc, 32'h8);
        cyc();
        chk("c5_ir", ir, 32'h10e6_2800);
        chk("c5_pc", ir_pc, 32'hC);

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", ir_valid, 0);
        chk("arst_ir", ir, 0);
        chk("arst_req", imem_req, 0);
`ifdef IFQ_STARVE_CNT_EN
        chk("arst_starve", starve_cnt, 0);
`endif
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        chk("rs_req", imem_req, 1);
        chk("rs_addr", imem_addr, 32'h0);
        cyc();
        cyc();

        // Stall held for 8 cycles from the first valid instruction.
        stall = 1'b1;
        #1;
        chk("st_valid", ir_valid, 1);
        chk("st_ir", ir, 32'h4470_7fff);
        for (int k = 3; k <= 9; k++) begin
            cyc();
            chk("st_hold_ir", ir, 32'h4470_7fff);
            chk("st_hold_pc", ir_pc, 32'h0);
            if (k == 3) chk("st_c3_addr", imem_addr, 32'hC);
            if (k >= 4) chk("st_req_low", imem_req, 0);
        end
        cyc();
        stall = 1'b0;
        #1;
        chk("rel_req_low", imem_req, 0);
        chk("rel_pc0", ir_pc, 32'h0);
        cyc();
        chk("rel_req", imem_req, 1);
        chk("rel_addr", imem_addr, 32'h10);
        chk("rel_pc4", ir_pc, 32'h4);
        cyc();
        chk("rel_pc8", ir_pc, 32'h8);
        cyc();
        chk("rel_pcc", ir_pc, 32'hC);
        cyc();
        chk("rel_pc10_v", ir_valid, 1);
        chk("rel_pc10", ir_pc, 32'h10);

        // Redirect with two entries queued and one in flight.
        cyc();
`ifdef IFQ_STARVE_CNT_EN
        s0 = starve_cnt;
`endif
        redirect = 1'b1;
        redirect_pc = 32'h0000_0102;
        #1;
        chk("rd_req_low", imem_req, 0);
        cyc();
        redirect = 1'b0;
        #1;
        chk("rd_req", imem_req, 1);
        chk("rd_addr", imem_addr, 32'h100);
        chk("rd_gap1", ir_valid, 0);
        cyc();
        chk("rd_gap2", ir_valid, 0);
        cyc();
        chk("rd_valid", ir_valid, 1);
        chk("rd_pc", ir_pc, 32'h100);
        chk("rd_ir", ir, memword(32'h100));
`ifdef IFQ_STARVE_CNT_EN
        chk("starve_redir", starve_cnt, s0 + 16'd2);
`endif
        cyc();
        cyc();
        chk("pre_bb_valid", ir_valid, 1);

        // Redirect coinciding with a pop, then a second redirect.
        redirect = 1'b1;
        redirect_pc = 32'h40;
        #1;
        chk("bb1_req_low", imem_req, 0);
        cyc();
        redirect_pc = 32'h80;
        #1;
        chk("bb2_empty", ir_valid, 0);
        chk("bb2_req_low", imem_req, 0);
        cyc();
        redirect = 1'b0;
        #1;
        chk("bb_req", imem_req, 1);
        chk("bb_addr", imem_addr, 32'h80);
        cyc();
        chk("bb_gap", ir_valid, 0);
        cyc();
        chk("bb_valid", ir_valid, 1);
        chk("bb_pc", ir_pc, 32'h80);
        chk("bb_ir", ir, memword(32'h80));
        cyc();
        cyc();

`ifdef IFQ_STARVE_CNT_EN
        // Forced starvation saturates the counter.
        redirect = 1'b1;
        repeat (70000) cyc();
        chk("starve_sat", starve_cnt, 16'hFFFF);
        redirect = 1'b0;
        cyc();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
